// File: rtl/alu_arbiter_if.sv
// Bus bundle between the requesters, the shared ALU and the response consumer
// on one side and alu_arbiter on the other.
interface alu_arbiter_if #(
   parameter int WIDTH = 32
);
   logic             r0_valid;
   logic             r1_valid;
   logic             r0_ready;
   logic             r1_ready;
   logic [3:0]       r0_op;
   logic [3:0]       r1_op;
   logic [WIDTH-1:0] r0_a;
   logic [WIDTH-1:0] r0_b;
   logic [WIDTH-1:0] r1_a;
   logic [WIDTH-1:0] r1_b;
   logic [3:0]       alu_op;
   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [WIDTH-1:0] alu_result;
   logic             alu_zero;
   logic             rsp_valid;
   logic             rsp_ready;
   logic             rsp_id;
   logic [WIDTH-1:0] rsp_result;
   logic             rsp_zero;
   logic             rsp_illegal;
   logic             busy;

   modport slave (
      input  r0_valid, r1_valid, r0_op, r1_op, r0_a, r0_b, r1_a, r1_b,
      input  alu_result, alu_zero, rsp_ready,
      output r0_ready, r1_ready, alu_op, alu_a, alu_b,
      output rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy
   );

   modport master (
      output r0_valid, r1_valid, r0_op, r1_op, r0_a, r0_b, r1_a, r1_b,
      output alu_result, alu_zero, rsp_ready,
      input  r0_ready, r1_ready, alu_op, alu_a, alu_b,
      input  rsp_valid, rsp_id, rsp_result, rsp_zero, rsp_illegal, busy
   );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin arbiter/sequencer sharing one combinational ALU between two
// requesters: IDLE grants and latches, EXEC captures the ALU, RESP holds the tagged response.
module alu_arbiter #(
   parameter int WIDTH = 32
) (
   input  logic          clk,
   input  logic          rst_n,
   alu_arbiter_if.slave  bus
);
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_EXEC = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]       state_q, state_d;
   logic             last_grant_q, last_grant_d;
   logic [3:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic             id_q, id_d;
   logic             rsp_valid_q, rsp_valid_d;
   logic             rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0] rsp_result_q, rsp_result_d;
   logic             rsp_zero_q, rsp_zero_d;
   logic             rsp_illegal_q, rsp_illegal_d;
   logic             busy_q, busy_d;
   logic             grant0_s, grant1_s, accept_s;

   function automatic logic op_illegal(input logic [3:0] op);
      return (op < 4'h9) || (op > 4'hC);
   endfunction

   // Grant: a tie goes to the requester not served last.
   always_comb begin
      grant0_s = 1'b0;
      grant1_s = 1'b0;
      if (state_q == ST_IDLE) begin
         if (bus.r0_valid && bus.r1_valid) begin
            grant0_s = last_grant_q;
            grant1_s = ~last_grant_q;
         end else begin
            grant0_s = bus.r0_valid;
            grant1_s = bus.r1_valid;
         end
      end else begin
         grant0_s = 1'b0;
         grant1_s = 1'b0;
      end
   end

   assign accept_s = grant0_s | grant1_s;

   // Next-state and datapath capture for the three-phase sequence.
   always_comb begin
      state_d       = state_q;
      last_grant_d  = last_grant_q;
      op_d          = op_q;
      a_d           = a_q;
      b_d           = b_q;
      id_d          = id_q;
      rsp_valid_d   = rsp_valid_q;
      rsp_id_d      = rsp_id_q;
      rsp_result_d  = rsp_result_q;
      rsp_zero_d    = rsp_zero_q;
      rsp_illegal_d = rsp_illegal_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               op_d         = grant1_s ? bus.r1_op : bus.r0_op;
               a_d          = grant1_s ? bus.r1_a  : bus.r0_a;
               b_d          = grant1_s ? bus.r1_b  : bus.r0_b;
               id_d         = grant1_s;
               last_grant_d = grant1_s;
               state_d      = ST_EXEC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_EXEC: begin
            rsp_result_d  = bus.alu_result;
            rsp_zero_d    = bus.alu_zero;
            rsp_illegal_d = op_illegal(op_q);
            rsp_id_d      = id_q;
            rsp_valid_d   = 1'b1;
            state_d       = ST_RESP;
         end
         ST_RESP: begin
            if (bus.rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = ST_IDLE;
            end else begin
               state_d = ST_RESP;
            end
         end
         default: begin
            rsp_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset also discards any in-flight response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_IDLE;
         last_grant_q  <= 1'b1;
         op_q          <= 4'h0;
         a_q           <= {WIDTH{1'b0}};
         b_q           <= {WIDTH{1'b0}};
         id_q          <= 1'b0;
         rsp_valid_q   <= 1'b0;
         rsp_id_q      <= 1'b0;
         rsp_result_q  <= {WIDTH{1'b0}};
         rsp_zero_q    <= 1'b0;
         rsp_illegal_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         last_grant_q  <= last_grant_d;
         op_q          <= op_d;
         a_q           <= a_d;
         b_q           <= b_d;
         id_q          <= id_d;
         rsp_valid_q   <= rsp_valid_d;
         rsp_id_q      <= rsp_id_d;
         rsp_result_q  <= rsp_result_d;
         rsp_zero_q    <= rsp_zero_d;
         rsp_illegal_q <= rsp_illegal_d;
         busy_q        <= busy_d;
      end
   end

   assign bus.r0_ready    = grant0_s;
   assign bus.r1_ready    = grant1_s;
   assign bus.alu_op      = op_q;
   assign bus.alu_a       = a_q;
   assign bus.alu_b       = b_q;
   assign bus.rsp_valid   = rsp_valid_q;
   assign bus.rsp_id      = rsp_id_q;
   assign bus.rsp_result  = rsp_result_q;
   assign bus.rsp_zero    = rsp_zero_q;
   assign bus.rsp_illegal = rsp_illegal_q;
   assign bus.busy        = busy_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural ALU on the alu_* side.
module tb_alu_arbiter;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   logic [31:0] alu_res_s;

   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(32)) bus ();

   alu_arbiter #(.WIDTH(32)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Reference ALU: illegal codes yield zero.
   always_comb begin
      case (bus.alu_op)
         4'h9:    alu_res_s = bus.alu_a + bus.alu_b;
         4'hA:    alu_res_s = bus.alu_a - bus.alu_b;
         4'hB:    alu_res_s = bus.alu_a & bus.alu_b;
         4'hC:    alu_res_s = bus.alu_a | bus.alu_b;
         default: alu_res_s = 32'h0;
      endcase
   end
   assign bus.alu_result = alu_res_s;
   assign bus.alu_zero   = (alu_res_s == 32'h0);

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Raise valid, wait (bounded) for ready, complete the handshake; returns in EXEC.
   task automatic issue(input bit rq, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      bit got;
      got = 1'b0;
      if (rq == 1'b0) begin
         bus.r0_valid = 1'b1; bus.r0_op = op; bus.r0_a = a; bus.r0_b = b;
      end else begin
         bus.r1_valid = 1'b1; bus.r1_op = op; bus.r1_a = a; bus.r1_b = b;
      end
      #1;
      for (int i = 0; i < 10; i++) begin
         if ((rq == 1'b0 && bus.r0_ready) || (rq == 1'b1 && bus.r1_ready)) begin
            got = 1'b1;
            break;
         end
         tick();
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL issue_ready req=%0d: ready never rose, required 1", rq);
      end
      tick();
      if (rq == 1'b0) bus.r0_valid = 1'b0;
      else            bus.r1_valid = 1'b0;
   endtask

   task automatic test_reset();
      bus.r0_valid = 1'b0; bus.r1_valid = 1'b0; bus.rsp_ready = 1'b0;
      bus.r0_op = 4'h0; bus.r1_op = 4'h0;
      bus.r0_a = 32'h0; bus.r0_b = 32'h0; bus.r1_a = 32'h0; bus.r1_b = 32'h0;
      #12;
      checks++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 68'h0) begin
         errors++; $display("FAIL reset_alu got op=%h a=%h b=%h required 0", bus.alu_op, bus.alu_a, bus.alu_b);
      end
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal, bus.busy} !== 37'h0) begin
         errors++; $display("FAIL reset_rsp got v=%b id=%b res=%h z=%b ill=%b busy=%b required all 0",
            bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal, bus.busy);
      end
      rst_n = 1'b1;
      tick();
      checks++;
      if ({bus.r0_ready, bus.r1_ready, bus.busy} !== 3'b000) begin
         errors++; $display("FAIL idle_readys got r0=%b r1=%b busy=%b required 000", bus.r0_ready, bus.r1_ready, bus.busy);
      end
   endtask

   task automatic test_single();
      bus.rsp_ready = 1'b1;
      issue(1'b0, 4'h9, 32'd5, 32'd7);
      checks++;
      if ({bus.busy, bus.rsp_valid, bus.r0_ready} !== 3'b100 || bus.alu_op !== 4'h9 || bus.alu_a !== 32'd5 || bus.alu_b !== 32'd7) begin
         errors++; $display("FAIL single_exec got busy=%b v=%b rdy=%b op=%h a=%0d b=%0d required busy=1 v=0 rdy=0 op=9 a=5 b=7",
            bus.busy, bus.rsp_valid, bus.r0_ready, bus.alu_op, bus.alu_a, bus.alu_b);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'd12 || bus.rsp_zero !== 1'b0 || bus.rsp_illegal !== 1'b0) begin
         errors++; $display("FAIL single_rsp got v=%b id=%b res=%0d z=%b ill=%b required v=1 id=0 res=12 z=0 ill=0",
            bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal);
      end
      tick();
      checks++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
         errors++; $display("FAIL single_idle got v=%b busy=%b required 00", bus.rsp_valid, bus.busy);
      end
   endtask

   task automatic test_wrap_zero();
      issue(1'b1, 4'hA, 32'd0, 32'd1);
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b1 || bus.rsp_result !== 32'hFFFF_FFFF || bus.rsp_zero !== 1'b0) begin
         errors++; $display("FAIL wrap_rsp got v=%b id=%b res=%h z=%b required v=1 id=1 res=ffffffff z=0",
            bus.rsp_valid, bus.rsp_id, bus.rsp_result, bus.rsp_zero);
      end
      tick();
      issue(1'b1, 4'hA, 32'd9, 32'd9);
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h0 || bus.rsp_zero !== 1'b1) begin
         errors++; $display("FAIL zero_rsp got v=%b res=%h z=%b required v=1 res=0 z=1", bus.rsp_valid, bus.rsp_result, bus.rsp_zero);
      end
      tick();
   endtask

   task automatic test_fairness();
      logic exp1;
      bus.rsp_ready = 1'b1;
      bus.r0_valid = 1'b1; bus.r0_op = 4'h9; bus.r0_a = 32'd1;  bus.r0_b = 32'd2;
      bus.r1_valid = 1'b1; bus.r1_op = 4'hA; bus.r1_a = 32'd10; bus.r1_b = 32'd4;
      #1;
      for (int k = 0; k < 4; k++) begin
         exp1 = (k % 2 == 1);
         checks++;
         if (bus.r0_ready !== ~exp1 || bus.r1_ready !== exp1) begin
            errors++; $display("FAIL fair_grant k=%0d got r0=%b r1=%b required r0=%b r1=%b", k, bus.r0_ready, bus.r1_ready, ~exp1, exp1);
         end
         tick();
         tick();
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== exp1 || bus.rsp_result !== (exp1 ? 32'd6 : 32'd3)) begin
            errors++; $display("FAIL fair_rsp k=%0d got v=%b id=%b res=%0d required v=1 id=%b res=%0d",
               k, bus.rsp_valid, bus.rsp_id, bus.rsp_result, exp1, exp1 ? 6 : 3);
         end
         tick();
      end
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
   endtask

   task automatic test_backpressure();
      bus.rsp_ready = 1'b0;
      bus.r0_valid = 1'b1; bus.r0_op = 4'hC; bus.r0_a = 32'hF0; bus.r0_b = 32'h0F;
      bus.r1_valid = 1'b1; bus.r1_op = 4'hB; bus.r1_a = 32'hFF; bus.r1_b = 32'h0F;
      #1;
      checks++;
      if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
         errors++; $display("FAIL bp_grant got r0=%b r1=%b required r0=1 r1=0", bus.r0_ready, bus.r1_ready);
      end
      tick();
      bus.r0_valid = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'hFF || bus.rsp_id !== 1'b0 ||
             bus.r0_ready !== 1'b0 || bus.r1_ready !== 1'b0 || bus.busy !== 1'b1) begin
            errors++; $display("FAIL bp_hold c=%0d got v=%b res=%h id=%b r0=%b r1=%b busy=%b required v=1 res=ff id=0 r0=0 r1=0 busy=1",
               c, bus.rsp_valid, bus.rsp_result, bus.rsp_id, bus.r0_ready, bus.r1_ready, bus.busy);
         end
         tick();
      end
      bus.rsp_ready = 1'b1;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.r1_ready !== 1'b1) begin
         errors++; $display("FAIL bp_release got v=%b r1=%b required v=0 r1=1", bus.rsp_valid, bus.r1_ready);
      end
      tick();
      bus.r1_valid = 1'b0;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h0F || bus.rsp_id !== 1'b1) begin
         errors++; $display("FAIL bp_pending got v=%b res=%h id=%b required v=1 res=0f id=1", bus.rsp_valid, bus.rsp_result, bus.rsp_id);
      end
      tick();
   endtask

   task automatic test_illegal();
      issue(1'b0, 4'h3, 32'hFFFF, 32'hFFFF);
      checks++;
      if (bus.alu_op !== 4'h3) begin
         errors++; $display("FAIL illegal_op got %h required 3", bus.alu_op);
      end
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_result !== 32'h0 || bus.rsp_zero !== 1'b1 || bus.rsp_illegal !== 1'b1) begin
         errors++; $display("FAIL illegal_rsp got v=%b res=%h z=%b ill=%b required v=1 res=0 z=1 ill=1",
            bus.rsp_valid, bus.rsp_result, bus.rsp_zero, bus.rsp_illegal);
      end
      tick();
   endtask

   task automatic test_reset_midop();
      issue(1'b1, 4'h9, 32'd100, 32'd23);
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.busy !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.alu_a !== 32'h0 || bus.alu_op !== 4'h0) begin
         errors++; $display("FAIL midop_clear got busy=%b v=%b a=%h op=%h required 0", bus.busy, bus.rsp_valid, bus.alu_a, bus.alu_op);
      end
      tick();
      tick();
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         checks++;
         if (bus.rsp_valid !== 1'b0) begin
            errors++; $display("FAIL midop_stale c=%0d got v=%b required 0", c, bus.rsp_valid);
         end
         tick();
      end
      bus.r0_valid = 1'b1; bus.r0_op = 4'hB; bus.r0_a = 32'hC; bus.r0_b = 32'hA;
      bus.r1_valid = 1'b1; bus.r1_op = 4'h9; bus.r1_a = 32'd1; bus.r1_b = 32'd1;
      #1;
      checks++;
      if (bus.r0_ready !== 1'b1 || bus.r1_ready !== 1'b0) begin
         errors++; $display("FAIL midop_tie got r0=%b r1=%b required r0=1 r1=0", bus.r0_ready, bus.r1_ready);
      end
      tick();
      bus.r0_valid = 1'b0;
      bus.r1_valid = 1'b0;
      tick();
      checks++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_id !== 1'b0 || bus.rsp_result !== 32'h8) begin
         errors++; $display("FAIL midop_after got v=%b id=%b res=%h required v=1 id=0 res=8", bus.rsp_valid, bus.rsp_id, bus.rsp_result);
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_single();
      test_wrap_zero();
      test_fairness();
      test_backpressure();
      test_illegal();
      test_reset_midop();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-requester arbiter and sequencer that shares the processor's single combinational ALU (AND/OR/ADD/SUB) between independent clients, e.g. the execute stage and a multi-cycle helper unit. It accepts one operation at a time over a valid/ready handshake, drives the ALU from registered operands, captures the result and Zero flag, and returns them on a single tagged response channel with backpressure. It sits between the requesters and the ALU instance, which is wired to its `alu_*` ports.

## Interface
- `WIDTH`, 32, operand and result width; matches the ALU datapath.
- `clk`  in  1  single clock; all state updates on rising edge.
- `rst_n`  in  1  reset: one clock; reset is asynchronous and active-low.
- `r0_valid`, `r1_valid`  in  1  requester 0/1 has an operation pending.
- `r0_ready`, `r1_ready`  out  1  arbiter accepts that requester's operation this cycle.
- `r0_op`, `r1_op`  in  4  ALU operation code. Legal codes: 4'h9 ADD, 4'hA SUB, 4'hB AND, 4'hC OR.
- `r0_a`, `r0_b`, `r1_a`, `r1_b`  in  WIDTH  operands.
- `alu_op`  out  4  registered operation code to the ALU.
- `alu_a`, `alu_b`  out  WIDTH  registered operands to the ALU.
- `alu_result`  in  WIDTH  ALU result.
- `alu_zero`  in  1  ALU Zero flag.
- `rsp_valid`  out  1  response available.
- `rsp_ready`  in  1  consumer accepts the response.
- `rsp_id`  out  1  index of the requester that issued the operation.
- `rsp_result`  out  WIDTH  captured result.
- `rsp_zero`  out  1  captured Zero flag.
- `rsp_illegal`  out  1  op code was outside 9..C.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- IDLE:
  - Grant is combinational.
  - If exactly one `rN_valid` is high, grant that requester.
  - If both are high, grant the one not served last. `last_grant` resets to 1, so r0 wins the first tie.
  - Only the granted requester's `rN_ready` is high. Both readys are low outside IDLE.
  - On `valid && ready`: latch op, a, b and id into the operand registers, update `last_grant`, and go to EXEC.
- EXEC:
  - `alu_*` carry the latched operands for the whole cycle.
  - Capture `alu_result` into `rsp_result` and `alu_zero` into `rsp_zero`.
  - Set `rsp_illegal = (op < 4'h9 || op > 4'hC)`, then go to RESP.
- RESP:
  - `rsp_valid` is high.
  - All `rsp_*` outputs stay stable until `rsp_ready`.
  - On `rsp_valid && rsp_ready`, go to IDLE. `rsp_valid` deasserts the next cycle.
- Illegal ops are still executed. The ALU returns 0, so the response carries `rsp_result = 0`, `rsp_zero = 1`, `rsp_illegal = 1`.
- `alu_*` outputs hold the last latched operands while in IDLE and RESP; they change only on acceptance.
- Requester rule: a requester must hold valid and payload stable until ready. Dropping valid before a handshake is tolerated; the grant is re-evaluated every IDLE cycle.
- Arithmetic is modulo 2^WIDTH and handled by the ALU. The arbiter does no width extension.

## Timing
- Reset (async assert, sync-safe release) drives:
  - state = IDLE, `last_grant` = 1;
  - `alu_op`, `alu_a`, `alu_b` = 0;
  - `rsp_valid`, `rsp_id`, `rsp_result`, `rsp_zero`, `rsp_illegal` = 0;
  - `busy` = 0.
- Accept on edge T (handshake in cycle T-1): cycle T is EXEC, and `rsp_valid` = 1 from cycle T+1.
- Accept-to-response latency is 2 cycles.
- With `rsp_ready` held high, the FSM is back in IDLE at T+2 and can accept again. Peak throughput is one op per 3 cycles.
- `rN_ready` depends only on state, valids and `last_grant`, never on `rsp_ready`.
- Reset asserted mid-operation (EXEC or RESP) aborts it. The in-flight response is discarded and never presented.

## Test plan
- Single op: r0 ADD 5 + 7 → `rsp_valid` 2 cycles after the handshake with `rsp_id=0`, `rsp_result=12`, `rsp_zero=0`, `rsp_illegal=0`.
- Wrap and zero:
  - r1 SUB 0 − 1 → `rsp_result=32'hFFFFFFFF`, `rsp_zero=0`, `rsp_id=1`.
  - r1 SUB 9 − 9 → `rsp_result=0`, `rsp_zero=1`.
- Fairness: both valid continuously with distinct ops, `rsp_ready=1` → grants r0, r1, r0, r1; responses every 3 cycles, in order.
- Backpressure: hold `rsp_ready=0` for 5 cycles in RESP → `rsp_*` stable, both readys low, `busy=1`. Release → IDLE next cycle and the pending requester is accepted.
- Illegal op: r0 op 4'h3 with a=b=32'hFFFF → `rsp_result=0`, `rsp_zero=1`, `rsp_illegal=1`.
- Reset mid-op: assert `rst_n=0` during EXEC → outputs clear immediately. After release, no stale response appears; `last_grant=1`, so a tie grants r0.
